hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination writers per stage,
// produces per-stage forwarding selects and a decode stall on not-yet-ready
// producers.
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int TW    = 2,
    localparam int SW   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [AW-1:0]       d_rs,
    input  logic [AW-1:0]       d_rt,
    input  logic                d_rs_use,
    input  logic                d_rt_use,
    input  logic [TW-1:0]       d_rs_tuse,
    input  logic [TW-1:0]       d_rt_tuse,
    input  logic [AW-1:0]       d_dst,
    input  logic                d_we,
    input  logic [TW-1:0]       d_tnew,
    input  logic                flush_e,
    output logic                stall,
    output logic [DEPTH*SW-1:0] sel_rs,
    output logic [DEPTH*SW-1:0] sel_rt
);

    // Per-stage entries, index k = 1 (E) .. DEPTH.
    // ent_valid is the "eligible to match" bit: a real writer with dst != 0.
    logic          ent_valid [1:DEPTH];
    logic [AW-1:0] ent_dst   [1:DEPTH];
    logic [TW-1:0] ent_tnew  [1:DEPTH];
    // Source fields are only consulted by consumer stages 1..DEPTH-1; the
    // last stage never consumes, so its copy is not kept.
    logic [AW-1:0] ent_rs    [1:DEPTH-1];
    logic [AW-1:0] ent_rt    [1:DEPTH-1];

    // Consumer source addresses, index c = 0 (D) .. DEPTH-1.
    logic [AW-1:0] src_rs [0:DEPTH-1];
    logic [AW-1:0] src_rt [0:DEPTH-1];

    // Winning (youngest) match per consumer stage.
    logic          hit_rs [0:DEPTH-1];
    logic          hit_rt [0:DEPTH-1];
    logic [SW-1:0] k_rs   [0:DEPTH-1];
    logic [SW-1:0] k_rt   [0:DEPTH-1];
    logic [TW-1:0] tn_rs  [0:DEPTH-1];
    logic [TW-1:0] tn_rt  [0:DEPTH-1];

    logic load_e;

    assign load_e = d_valid & ~stall & ~flush_e;

    // Stage entries: E loads decode or a bubble; older stages always advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_dst[k]   <= '0;
                ent_tnew[k]  <= '0;
            end
            for (int unsigned k = 1; k <= DEPTH - 1; k++) begin
                ent_rs[k] <= '0;
                ent_rt[k] <= '0;
            end
        end else begin
            if (load_e) begin
                ent_valid[1] <= d_we & (d_dst != '0);
                ent_dst[1]   <= d_dst;
                ent_tnew[1]  <= d_tnew;
                ent_rs[1]    <= d_rs;
                ent_rt[1]    <= d_rt;
            end else begin
                ent_valid[1] <= 1'b0;
                ent_dst[1]   <= '0;
                ent_tnew[1]  <= '0;
                ent_rs[1]    <= '0;
                ent_rt[1]    <= '0;
            end
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_dst[k]   <= ent_dst[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            end
            for (int unsigned k = 2; k <= DEPTH - 1; k++) begin
                ent_rs[k] <= ent_rs[k-1];
                ent_rt[k] <= ent_rt[k-1];
            end
        end
    end

    // Consumer source addresses: decode inputs at D, stored fields beyond.
    always_comb begin
        src_rs[0] = d_rs;
        src_rt[0] = d_rt;
        for (int unsigned c = 1; c <= DEPTH - 1; c++) begin
            src_rs[c] = ent_rs[c];
            src_rt[c] = ent_rt[c];
        end
    end

    // Youngest-match search: scan from oldest to youngest so the smallest k
    // producing a match is the one left standing.
    always_comb begin
        for (int unsigned c = 0; c <= DEPTH - 1; c++) begin
            hit_rs[c] = 1'b0;
            k_rs[c]   = '0;
            tn_rs[c]  = '0;
            hit_rt[c] = 1'b0;
            k_rt[c]   = '0;
            tn_rt[c]  = '0;
            for (int unsigned k = DEPTH; k > c; k--) begin
                if (ent_valid[k] && (src_rs[c] != '0) && (ent_dst[k] == src_rs[c])) begin
                    hit_rs[c] = 1'b1;
                    k_rs[c]   = SW'(k);
                    tn_rs[c]  = ent_tnew[k];
                end
                if (ent_valid[k] && (src_rt[c] != '0) && (ent_dst[k] == src_rt[c])) begin
                    hit_rt[c] = 1'b1;
                    k_rt[c]   = SW'(k);
                    tn_rt[c]  = ent_tnew[k];
                end
            end
        end
    end

    // Forward selects and decode stall, forced quiet while reset is held.
    always_comb begin
        stall  = 1'b0;
        sel_rs = '0;
        sel_rt = '0;
        if (!reset) begin
            for (int unsigned c = 0; c <= DEPTH - 1; c++) begin
                if (hit_rs[c] && (tn_rs[c] == '0)) begin
                    sel_rs[c*SW +: SW] = k_rs[c];
                end
                if (hit_rt[c] && (tn_rt[c] == '0)) begin
                    sel_rt[c*SW +: SW] = k_rt[c];
                end
            end
            stall = d_valid &
                    ((d_rs_use & hit_rs[0] & (tn_rs[0] > d_rs_tuse)) |
                     (d_rt_use & hit_rt[0] & (tn_rt[0] > d_rt_tuse)));
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// randomized traffic against a pipeline-level reference model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int AW    = 5;
    localparam int TW    = 2;
    localparam int SW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                d_valid;
    logic [AW-1:0]       d_rs, d_rt, d_dst;
    logic                d_rs_use, d_rt_use, d_we;
    logic [TW-1:0]       d_rs_tuse, d_rt_tuse, d_tnew;
    logic                flush_e;
    logic                stall;
    logic [DEPTH*SW-1:0] sel_rs, sel_rt;

    int checks = 0;
    int fails  = 0;

    hazard_scoreboard #(.DEPTH(DEPTH), .AW(AW), .TW(TW)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_we(d_we), .d_tnew(d_tnew), .flush_e(flush_e),
        .stall(stall), .sel_rs(sel_rs), .sel_rt(sel_rt)
    );

    always #5 clk = ~clk;

    // Reference model: what each pipeline stage currently holds.
    typedef struct {
        bit v;      // real writer of a nonzero register
        int dst;
        int tnew;
        int rs;
        int rt;
    } ent_t;

    ent_t m [1:DEPTH];

    function automatic void m_clear();
        for (int k = 1; k <= DEPTH; k++) m[k] = '{0, 0, 0, 0, 0};
    endfunction

    function automatic int m_src(int c, bit is_rs);
        if (c == 0) return is_rs ? int'(d_rs) : int'(d_rt);
        return is_rs ? m[c].rs : m[c].rt;
    endfunction

    // Youngest producer older than consumer stage c that writes s.
    function automatic int m_win(int c, int s);
        for (int k = c + 1; k <= DEPTH; k++)
            if (m[k].v && m[k].dst == s && s != 0) return k;
        return 0;
    endfunction

    function automatic logic [DEPTH*SW-1:0] m_sel(bit is_rs);
        logic [DEPTH*SW-1:0] r;
        int k;
        r = '0;
        if (reset) return r;
        for (int c = 0; c < DEPTH; c++) begin
            k = m_win(c, m_src(c, is_rs));
            if (k != 0 && m[k].tnew == 0) r[c*SW +: SW] = SW'(k);
        end
        return r;
    endfunction

    function automatic bit m_stall();
        int k;
        if (reset || !d_valid) return 0;
        k = m_win(0, int'(d_rs));
        if (d_rs_use && k != 0 && m[k].tnew > int'(d_rs_tuse)) return 1;
        k = m_win(0, int'(d_rt));
        if (d_rt_use && k != 0 && m[k].tnew > int'(d_rt_tuse)) return 1;
        return 0;
    endfunction

    function automatic void m_step(bit st);
        for (int k = DEPTH; k >= 2; k--) begin
            m[k] = m[k-1];
            m[k].tnew = (m[k-1].tnew > 0) ? m[k-1].tnew - 1 : 0;
        end
        if (d_valid && !st && !flush_e)
            m[1] = '{d_we && (d_dst != 0), int'(d_dst), int'(d_tnew), int'(d_rs), int'(d_rt)};
        else
            m[1] = '{0, 0, 0, 0, 0};
    endfunction

    // One clock: model follows the edge, returns at the next falling edge.
    task automatic tick();
        bit st;
        st = m_stall();
        @(posedge clk);
        if (reset) m_clear();
        else m_step(st);
        @(negedge clk);
    endtask

    task automatic set_idle();
        d_valid = 0; d_rs = '0; d_rt = '0; d_rs_use = 0; d_rt_use = 0;
        d_rs_tuse = '0; d_rt_tuse = '0; d_dst = '0; d_we = 0; d_tnew = '0;
        flush_e = 0;
    endtask

    task automatic dec(input int rs, input int rs_use, input int rs_tuse,
                       input int rt, input int rt_use, input int rt_tuse,
                       input int dst, input int we, input int tnew);
        d_valid = 1;
        d_rs = AW'(rs); d_rs_use = rs_use[0]; d_rs_tuse = TW'(rs_tuse);
        d_rt = AW'(rt); d_rt_use = rt_use[0]; d_rt_tuse = TW'(rt_tuse);
        d_dst = AW'(dst); d_we = we[0]; d_tnew = TW'(tnew);
    endtask

    task automatic apply_reset();
        set_idle();
        reset = 1;
        m_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        dec(3, 1, 0, 4, 1, 0, 3, 1, 3);
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if (sel_rs !== '0) begin fails++; $display("FAIL reset_sel_rs: got %h expected 0", sel_rs); end
        checks++;
        if (sel_rt !== '0) begin fails++; $display("FAIL reset_sel_rt: got %h expected 0", sel_rt); end
        set_idle();
    endtask

    task automatic test_load_use();
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 5, 1, 2);          // lw $5
        tick();
        dec(5, 1, 1, 0, 0, 0, 8, 1, 1);          // add reads $5
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall_first: got %b expected 1", stall); end
        tick();
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL load_use_stall_second: got %b expected 0", stall); end
        tick();
        set_idle();
        #1;
        checks++;
        if (sel_rs[1*SW +: SW] !== SW'(3))
            begin fails++; $display("FAIL load_use_sel_rs1: got %0d expected 3", sel_rs[1*SW +: SW]); end
    endtask

    task automatic test_branch();
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 3, 1, 1);          // addu $3
        tick();
        dec(3, 1, 0, 0, 0, 0, 0, 0, 0);          // beq reads $3
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL branch_stall_first: got %b expected 1", stall); end
        tick();
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL branch_stall_second: got %b expected 0", stall); end
        checks++;
        if (sel_rs[0 +: SW] !== SW'(2))
            begin fails++; $display("FAIL branch_sel_rs0: got %0d expected 2", sel_rs[0 +: SW]); end
    endtask

    task automatic test_store_data();
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 7, 1, 2);          // lw $7
        tick();
        dec(0, 0, 0, 7, 1, 2, 0, 0, 0);          // sw rt=$7
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL store_no_stall: got %b expected 0", stall); end
        tick();
        set_idle();
        tick();
        #1;
        checks++;
        if (sel_rt[2*SW +: SW] !== SW'(3))
            begin fails++; $display("FAIL store_sel_rt2: got %0d expected 3", sel_rt[2*SW +: SW]); end
        dec(0, 0, 0, 0, 0, 0, 0, 1, 0);          // writer of $0
        tick();
        dec(0, 0, 0, 0, 1, 2, 0, 0, 0);          // sw rt=$0
        tick();
        set_idle();
        tick();
        #1;
        checks++;
        if (sel_rt[2*SW +: SW] !== SW'(0))
            begin fails++; $display("FAIL store_r0_sel_rt2: got %0d expected 0", sel_rt[2*SW +: SW]); end
    endtask

    task automatic test_youngest();
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 31, 1, 0);         // older $31 writer
        tick();
        set_idle();
        tick();
        dec(0, 0, 0, 0, 0, 0, 31, 1, 0);         // jal
        tick();
        dec(31, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (sel_rs[0 +: SW] !== SW'(1))
            begin fails++; $display("FAIL youngest_sel_rs0: got %0d expected 1", sel_rs[0 +: SW]); end
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL youngest_stall: got %b expected 0", stall); end
        // Younger producer not ready: the ready older one must not be used.
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 31, 1, 0);
        tick();
        set_idle();
        tick();
        dec(0, 0, 0, 0, 0, 0, 31, 1, 1);
        tick();
        dec(31, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL youngest_busy_stall: got %b expected 1", stall); end
        checks++;
        if (sel_rs[0 +: SW] !== SW'(0))
            begin fails++; $display("FAIL youngest_busy_sel_rs0: got %0d expected 0", sel_rs[0 +: SW]); end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 5, 1, 2);
        tick();
        dec(5, 1, 0, 5, 1, 0, 6, 1, 1);
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_stall: got %b expected 1", stall); end
        reset = 1;
        m_clear();
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL rst_mid_during_stall: got %b expected 0", stall); end
        checks++;
        if ((sel_rs | sel_rt) !== '0)
            begin fails++; $display("FAIL rst_mid_during_sel: got %h/%h expected 0", sel_rs, sel_rt); end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL rst_mid_after_stall: got %b expected 0", stall); end
        checks++;
        if ((sel_rs | sel_rt) !== '0)
            begin fails++; $display("FAIL rst_mid_after_sel: got %h/%h expected 0", sel_rs, sel_rt); end
        // Short pulse between edges must clear state on its own.
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 5, 1, 2);
        tick();
        dec(5, 1, 0, 0, 0, 0, 6, 1, 1);
        #1;
        reset = 1;
        m_clear();
        #1;
        reset = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL rst_pulse_stall: got %b expected 0", stall); end
        tick();
    endtask

    task automatic test_stall_flush();
        apply_reset();
        dec(0, 0, 0, 0, 0, 0, 9, 1, 3);          // slow $9 writer
        tick();
        dec(0, 0, 0, 0, 0, 0, 5, 1, 2);          // lw $5
        tick();
        dec(5, 1, 0, 9, 1, 3, 10, 1, 1);         // consumer of $5, flush at once
        flush_e = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL sf_stall_first: got %b expected 1", stall); end
        tick();
        flush_e = 0;
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL sf_stall_held: got %b expected 1", stall); end
        checks++;
        if (sel_rt[0 +: SW] !== SW'(0))
            begin fails++; $display("FAIL sf_sel_rt0: got %0d expected 0", sel_rt[0 +: SW]); end
        tick();
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL sf_stall_release: got %b expected 0", stall); end
        checks++;
        if (sel_rs[0 +: SW] !== SW'(3))
            begin fails++; $display("FAIL sf_sel_rs0: got %0d expected 3", sel_rs[0 +: SW]); end
        checks++;
        if (sel_rs[2*SW +: SW] !== SW'(0))
            begin fails++; $display("FAIL sf_sel_rs2_bubble: got %0d expected 0", sel_rs[2*SW +: SW]); end
        set_idle();
    endtask

    task automatic test_random();
        logic                e_stall;
        logic [DEPTH*SW-1:0] e_rs, e_rt;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            d_valid   = ($urandom_range(0, 3) != 0);
            d_rs      = AW'($urandom_range(0, 7));
            d_rt      = AW'($urandom_range(0, 7));
            d_rs_use  = 1'($urandom_range(0, 1));
            d_rt_use  = 1'($urandom_range(0, 1));
            d_rs_tuse = TW'($urandom_range(0, 3));
            d_rt_tuse = TW'($urandom_range(0, 3));
            d_dst     = AW'($urandom_range(0, 7));
            d_we      = ($urandom_range(0, 3) != 0);
            d_tnew    = TW'($urandom_range(0, 3));
            flush_e   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1;
                m_clear();
            end else begin
                reset = 0;
            end
            #1;
            e_stall = m_stall();
            e_rs    = m_sel(1);
            e_rt    = m_sel(0);
            checks++;
            if (stall !== e_stall)
                begin fails++; $display("FAIL rand_stall @%0d: got %b expected %b", i, stall, e_stall); end
            checks++;
            if (sel_rs !== e_rs)
                begin fails++; $display("FAIL rand_sel_rs @%0d: got %h expected %h", i, sel_rs, e_rs); end
            checks++;
            if (sel_rt !== e_rt)
                begin fails++; $display("FAIL rand_sel_rt @%0d: got %h expected %h", i, sel_rt, e_rt); end
            tick();
        end
        reset = 0;
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        set_idle();
        m_clear();
        repeat (2) @(negedge clk);
        test_reset();
        reset = 0;
        test_load_use();
        test_branch();
        test_store_data();
        test_youngest();
        test_reset_mid_stall();
        test_stall_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
